// File: rtl/conway_sequencer_if.sv
// Control/status bundle between the board-level UI logic and the
// conway_sequencer generation controller.
//   master : board side (buttons, period setting, grid liveness in; status out)
//   slave  : the sequencer itself
interface conway_sequencer_if #(
    parameter int PERIOD_W = 24,
    parameter int GEN_W    = 16
);
    logic                load;
    logic                run;
    logic                step;
    logic [PERIOD_W-1:0] period;
    logic                any_alive;
    logic                cells_rst;
    logic                cells_ena;
    logic [GEN_W-1:0]    generation;
    logic [1:0]          fsm_state;
    logic                extinct;

    modport master (
        output load, run, step, period, any_alive,
        input  cells_rst, cells_ena, generation, fsm_state, extinct
    );

    modport slave (
        input  load, run, step, period, any_alive,
        output cells_rst, cells_ena, generation, fsm_state, extinct
    );
endinterface

// File: rtl/conway_sequencer.sv
// Generation controller for the conway_cell grid. Drives the shared load
// strobe (cells_rst) and step strobe (cells_ena) of the cell array from
// load/run/step commands, counts generations and parks in HALT when the
// grid has died out.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | grid loaded and stable; single steps on request, waits for run
//   LOAD  | cells_rst held high for LOAD_CYCLES clocks, generation cleared
//   RUN   | free-running, one cells_ena strobe every max(period,1) clocks
//   HALT  | grid extinct; only a load request leaves this state
//
// Command priority at every edge is load > run > step. All outputs are
// registered, so cells_ena and cells_rst are glitch-free at the grid.
module conway_sequencer #(
    parameter int PERIOD_W    = 24,
    parameter int GEN_W       = 16,
    parameter int LOAD_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,  // active-low, asynchronous
    conway_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int                 LCNT_W    = $clog2(LOAD_CYCLES + 1);
    localparam logic [LCNT_W-1:0]  LOAD_INIT = LCNT_W'(LOAD_CYCLES);
    localparam logic [GEN_W-1:0]   GEN_MAX   = '1;

    state_t                state_q, state_d;
    logic [LCNT_W-1:0]     lcnt_q, lcnt_d;
    logic [PERIOD_W-1:0]   pcnt_q, pcnt_d;
    logic                  cells_rst_q, cells_rst_d;
    logic                  cells_ena_q, cells_ena_d;
    logic [GEN_W-1:0]      gen_q, gen_d;
    logic                  extinct_q, extinct_d;

    logic [PERIOD_W-1:0]   period_eff;
    logic [GEN_W-1:0]      gen_inc;

    // A programmed period of zero behaves as one clock per generation.
    assign period_eff = (bus.period == '0) ? PERIOD_W'(1) : bus.period;

    // Generation count sticks at all-ones; strobes to the grid continue.
    assign gen_inc = (gen_q == GEN_MAX) ? gen_q : gen_q + GEN_W'(1);

    // State, timers and registered outputs; reset lands directly in LOAD.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= LOAD;
            lcnt_q      <= LOAD_INIT;
            pcnt_q      <= '0;
            cells_rst_q <= 1'b1;
            cells_ena_q <= 1'b0;
            gen_q       <= '0;
            extinct_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lcnt_q      <= lcnt_d;
            pcnt_q      <= pcnt_d;
            cells_rst_q <= cells_rst_d;
            cells_ena_q <= cells_ena_d;
            gen_q       <= gen_d;
            extinct_q   <= extinct_d;
        end
    end

    // Next-state and next-output decode; outputs default to inactive.
    always_comb begin
        state_d     = state_q;
        lcnt_d      = lcnt_q;
        pcnt_d      = pcnt_q;
        cells_rst_d = 1'b0;
        cells_ena_d = 1'b0;
        gen_d       = gen_q;
        extinct_d   = 1'b0;

        if (bus.load) begin
            // Load beats everything, including a terminal count in RUN.
            state_d     = LOAD;
            lcnt_d      = LOAD_INIT;
            pcnt_d      = '0;
            gen_d       = '0;
            cells_rst_d = 1'b1;
        end else begin
            unique case (state_q)
                LOAD: begin
                    gen_d = '0;
                    if (lcnt_q <= LCNT_W'(1)) begin
                        state_d = IDLE;
                        lcnt_d  = '0;
                    end else begin
                        lcnt_d      = lcnt_q - LCNT_W'(1);
                        cells_rst_d = 1'b1;
                    end
                end

                IDLE: begin
                    if (bus.run) begin
                        state_d = RUN;
                        pcnt_d  = period_eff;
                    end else if (bus.step) begin
                        if (bus.any_alive) begin
                            cells_ena_d = 1'b1;
                            gen_d       = gen_inc;
                        end else begin
                            state_d   = HALT;
                            extinct_d = 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (!bus.run) begin
                        // Dropping run abandons the count, even at terminal.
                        state_d = IDLE;
                        pcnt_d  = '0;
                    end else if (pcnt_q <= PERIOD_W'(1)) begin
                        if (bus.any_alive) begin
                            cells_ena_d = 1'b1;
                            gen_d       = gen_inc;
                            pcnt_d      = period_eff;
                        end else begin
                            state_d   = HALT;
                            extinct_d = 1'b1;
                            pcnt_d    = '0;
                        end
                    end else begin
                        pcnt_d = pcnt_q - PERIOD_W'(1);
                    end
                end

                HALT: begin
                    extinct_d = 1'b1;
                end

                default: begin
                    state_d = LOAD;
                    lcnt_d  = LOAD_INIT;
                end
            endcase
        end
    end

    assign bus.cells_rst  = cells_rst_q;
    assign bus.cells_ena  = cells_ena_q;
    assign bus.generation = gen_q;
    assign bus.fsm_state  = state_q;
    assign bus.extinct    = extinct_q;

endmodule

// File: tb/tb_conway_sequencer.sv
// Bench for conway_sequencer. Expected cells_ena edges are derived from the
// command timing, pushed to exp_q when stimulus is driven and popped against
// the edges where the DUT actually strobed (obs).
module tb_conway_sequencer;

    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n  = 1'b1;

    always #5 if (clk_en) clk = ~clk;

    conway_sequencer_if #(.PERIOD_W(24), .GEN_W(16)) sif ();
    conway_sequencer_if #(.PERIOD_W(24), .GEN_W(3))  sif3 ();

    conway_sequencer #(.PERIOD_W(24), .GEN_W(16), .LOAD_CYCLES(2)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (sif)
    );

    conway_sequencer #(.PERIOD_W(24), .GEN_W(3), .LOAD_CYCLES(2)) dut3 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (sif3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    int ena3_cnt = 0;
    int viol     = 0;
    int exp_q[$];
    int obs[$];

    // One clock edge; sample 1 time unit after it and log strobes.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
        if (sif.cells_ena) obs.push_back(edge_n);
        if (sif3.cells_ena) ena3_cnt++;
        if (sif.cells_ena && sif.cells_rst) viol++;
    endtask

    task automatic do_load();
        sif.load = 1'b1;
        tick();
        sif.load = 1'b0;
        tick();
        tick();
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        sif.load = 0; sif.run = 0; sif.step = 0; sif.period = 24'd4; sif.any_alive = 1;
        sif3.load = 0; sif3.run = 0; sif3.step = 0; sif3.period = 24'd1; sif3.any_alive = 1;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (sif.cells_rst !== 1'b1) $display("FAIL rst_cells_rst: got %0b expected 1", sif.cells_rst); else n_pass++;
        n_checks++; if (sif.cells_ena !== 1'b0) $display("FAIL rst_ena: got %0b expected 0", sif.cells_ena); else n_pass++;
        n_checks++; if (sif.generation !== 16'd0) $display("FAIL rst_gen: got %0d expected 0", sif.generation); else n_pass++;
        n_checks++; if (sif.fsm_state !== 2'd1) $display("FAIL rst_state: got %0d expected 1", sif.fsm_state); else n_pass++;
        n_checks++; if (sif.extinct !== 1'b0) $display("FAIL rst_extinct: got %0b expected 0", sif.extinct); else n_pass++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (sif.cells_rst !== 1'b1) $display("FAIL load_hold1: got %0b expected 1", sif.cells_rst); else n_pass++;
        tick();
        n_checks++; if (sif.cells_rst !== 1'b0) $display("FAIL load_release: got %0b expected 0", sif.cells_rst); else n_pass++;
        n_checks++; if (sif.fsm_state !== 2'd0) $display("FAIL load_to_idle: got %0d expected 0", sif.fsm_state); else n_pass++;
        obs.delete();
    endtask

    task automatic test_step();
        int e;
        int o;
        do_load();
        sif.any_alive = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sif.step = 1'b1;
            tick();
            exp_q.push_back(edge_n);
            sif.step = 1'b0;
            tick();
            tick();
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : -1;
            n_checks++; if (o !== e) $display("FAIL step_ena_edge: got %0d expected %0d", o, e); else n_pass++;
        end
        n_checks++; if (obs.size() !== 0) $display("FAIL step_extra_ena: got %0d extra expected 0", obs.size()); else n_pass++;
        n_checks++; if (sif.generation !== 16'd3) $display("FAIL step_gen: got %0d expected 3", sif.generation); else n_pass++;
    endtask

    task automatic test_run();
        int e;
        int o;
        int e0;
        // period 4, run held through edge e0+20
        do_load();
        sif.period = 24'd4;
        sif.run = 1'b1;
        tick();
        e0 = edge_n;
        for (int k = 1; k <= 5; k++) exp_q.push_back(e0 + 4 * k);
        repeat (20) tick();
        sif.run = 1'b0;
        tick();
        // period 0 behaves as 1; run dropped with counter at 1
        sif.period = 24'd0;
        sif.run = 1'b1;
        tick();
        e0 = edge_n;
        for (int k = 1; k <= 6; k++) exp_q.push_back(e0 + k);
        repeat (6) tick();
        sif.run = 1'b0;
        tick();
        tick();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : -1;
            n_checks++; if (o !== e) $display("FAIL run_ena_edge: got %0d expected %0d", o, e); else n_pass++;
        end
        n_checks++; if (obs.size() !== 0) $display("FAIL run_extra_ena: got %0d extra expected 0", obs.size()); else n_pass++;
        n_checks++; if (sif.generation !== 16'd11) $display("FAIL run_gen: got %0d expected 11", sif.generation); else n_pass++;
        n_checks++; if (sif.fsm_state !== 2'd0) $display("FAIL run_stop_idle: got %0d expected 0", sif.fsm_state); else n_pass++;

        // period 4, run dropped exactly at the terminal-count edge
        do_load();
        sif.period = 24'd4;
        sif.run = 1'b1;
        tick();
        repeat (3) tick();
        sif.run = 1'b0;
        tick();
        tick();
        n_checks++; if (obs.size() !== 0) $display("FAIL run_drop_tc: got %0d enas expected 0", obs.size()); else n_pass++;

        // period change mid-run applies at the next reload
        do_load();
        sif.period = 24'd2;
        sif.run = 1'b1;
        tick();
        e0 = edge_n;
        exp_q.push_back(e0 + 2);
        exp_q.push_back(e0 + 7);
        exp_q.push_back(e0 + 12);
        tick();
        sif.period = 24'd5;
        repeat (11) tick();
        sif.run = 1'b0;
        tick();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : -1;
            n_checks++; if (o !== e) $display("FAIL period_change_edge: got %0d expected %0d", o, e); else n_pass++;
        end
        n_checks++; if (obs.size() !== 0) $display("FAIL period_change_extra: got %0d extra expected 0", obs.size()); else n_pass++;
    endtask

    task automatic test_extinction();
        int e;
        int o;
        int e0;
        do_load();
        sif.any_alive = 1'b1;
        sif.period = 24'd3;
        sif.run = 1'b1;
        tick();
        e0 = edge_n;
        exp_q.push_back(e0 + 3);
        repeat (3) tick();
        sif.any_alive = 1'b0;
        repeat (3) tick();
        n_checks++; if (sif.fsm_state !== 2'd3) $display("FAIL ext_state: got %0d expected 3", sif.fsm_state); else n_pass++;
        n_checks++; if (sif.extinct !== 1'b1) $display("FAIL ext_flag: got %0b expected 1", sif.extinct); else n_pass++;
        sif.step = 1'b1;
        tick();
        sif.step = 1'b0;
        sif.run = 1'b0;
        tick();
        sif.run = 1'b1;
        repeat (2) tick();
        n_checks++; if (sif.fsm_state !== 2'd3) $display("FAIL ext_sticky: got %0d expected 3", sif.fsm_state); else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : -1;
            n_checks++; if (o !== e) $display("FAIL ext_ena_edge: got %0d expected %0d", o, e); else n_pass++;
        end
        n_checks++; if (obs.size() !== 0) $display("FAIL ext_extra_ena: got %0d extra expected 0", obs.size()); else n_pass++;
        sif.run = 1'b0;
        sif.load = 1'b1;
        tick();
        sif.load = 1'b0;
        n_checks++; if (sif.fsm_state !== 2'd1) $display("FAIL ext_reload_state: got %0d expected 1", sif.fsm_state); else n_pass++;
        n_checks++; if (sif.extinct !== 1'b0) $display("FAIL ext_reload_flag: got %0b expected 0", sif.extinct); else n_pass++;
        n_checks++; if (sif.generation !== 16'd0) $display("FAIL ext_reload_gen: got %0d expected 0", sif.generation); else n_pass++;
        tick();
        tick();
        sif.step = 1'b1;
        tick();
        sif.step = 1'b0;
        n_checks++; if (sif.fsm_state !== 2'd3) $display("FAIL ext_step_dead: got %0d expected 3", sif.fsm_state); else n_pass++;
        n_checks++; if (obs.size() !== 0) $display("FAIL ext_step_dead_ena: got %0d enas expected 0", obs.size()); else n_pass++;
        sif.any_alive = 1'b1;
    endtask

    task automatic test_contention();
        int e;
        int o;
        int e0;
        do_load();
        sif.period = 24'd2;
        sif.load = 1'b1;
        sif.step = 1'b1;
        tick();
        n_checks++; if (sif.fsm_state !== 2'd1) $display("FAIL load_step_state: got %0d expected 1", sif.fsm_state); else n_pass++;
        n_checks++; if (sif.cells_ena !== 1'b0) $display("FAIL load_step_ena: got %0b expected 0", sif.cells_ena); else n_pass++;
        sif.load = 1'b0;
        sif.step = 1'b0;
        tick();
        tick();
        sif.load = 1'b1;
        sif.run = 1'b1;
        tick();
        n_checks++; if (sif.fsm_state !== 2'd1) $display("FAIL load_run_state: got %0d expected 1", sif.fsm_state); else n_pass++;
        sif.load = 1'b0;
        sif.run = 1'b0;
        tick();
        tick();
        n_checks++; if (obs.size() !== 0) $display("FAIL load_cont_ena: got %0d enas expected 0", obs.size()); else n_pass++;
        // load landing on a terminal-count edge mid-run
        sif.run = 1'b1;
        tick();
        e0 = edge_n;
        exp_q.push_back(e0 + 2);
        repeat (3) tick();
        sif.load = 1'b1;
        tick();
        n_checks++; if (sif.cells_rst !== 1'b1) $display("FAIL midrun_load_rst: got %0b expected 1", sif.cells_rst); else n_pass++;
        n_checks++; if (sif.generation !== 16'd0) $display("FAIL midrun_load_gen: got %0d expected 0", sif.generation); else n_pass++;
        n_checks++; if (sif.cells_ena !== 1'b0) $display("FAIL midrun_load_ena: got %0b expected 0", sif.cells_ena); else n_pass++;
        sif.load = 1'b0;
        sif.run = 1'b0;
        tick();
        tick();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = (obs.size() != 0) ? obs.pop_front() : -1;
            n_checks++; if (o !== e) $display("FAIL midrun_ena_edge: got %0d expected %0d", o, e); else n_pass++;
        end
        n_checks++; if (obs.size() !== 0) $display("FAIL midrun_extra_ena: got %0d extra expected 0", obs.size()); else n_pass++;
    endtask

    task automatic test_limits();
        sif3.period = 24'd1;
        sif3.any_alive = 1'b1;
        sif3.run = 1'b1;
        sif.period = 24'd3;
        sif.run = 1'b1;
        ena3_cnt = 0;
        repeat (11) tick();
        n_checks++; if (sif3.generation !== 3'd7) $display("FAIL sat_gen: got %0d expected 7", sif3.generation); else n_pass++;
        n_checks++; if (ena3_cnt !== 10) $display("FAIL sat_ena_count: got %0d expected 10", ena3_cnt); else n_pass++;
        n_checks++; if (sif3.fsm_state !== 2'd2) $display("FAIL sat_state: got %0d expected 2", sif3.fsm_state); else n_pass++;
        // freeze the clock low, then assert reset with no edges
        @(negedge clk);
        clk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (sif3.cells_rst !== 1'b1) $display("FAIL arst_cells_rst: got %0b expected 1", sif3.cells_rst); else n_pass++;
        n_checks++; if (sif3.cells_ena !== 1'b0) $display("FAIL arst_ena: got %0b expected 0", sif3.cells_ena); else n_pass++;
        n_checks++; if (sif3.generation !== 3'd0) $display("FAIL arst_gen: got %0d expected 0", sif3.generation); else n_pass++;
        n_checks++; if (sif3.fsm_state !== 2'd1) $display("FAIL arst_state: got %0d expected 1", sif3.fsm_state); else n_pass++;
        n_checks++; if (sif3.extinct !== 1'b0) $display("FAIL arst_extinct: got %0b expected 0", sif3.extinct); else n_pass++;
        n_checks++; if (sif.fsm_state !== 2'd1) $display("FAIL arst_main_state: got %0d expected 1", sif.fsm_state); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_extinction();
        test_contention();
        test_limits();
        n_checks++; if (viol !== 0) $display("FAIL ena_with_rst: got %0d overlaps expected 0", viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
